// File: rtl/lcd_byte_writer_pkg.sv
// Shared types, 50 MHz timing defaults and init helpers for the character-LCD byte writer.
package lcd_byte_writer_pkg;

  localparam int unsigned LCD_T_POWERUP = 750000;
  localparam int unsigned LCD_T_INIT1   = 205000;
  localparam int unsigned LCD_T_INIT2   = 5000;
  localparam int unsigned LCD_T_CMD     = 2000;
  localparam int unsigned LCD_T_CLEAR   = 82000;
  localparam int unsigned LCD_T_SETUP   = 2;
  localparam int unsigned LCD_T_PULSE   = 12;
  localparam int unsigned LCD_T_HOLD    = 1;
  localparam int unsigned LCD_T_NIBGAP  = 50;
  localparam int unsigned LCD_CNT_W     = 20;

  typedef enum logic [2:0] {
    S_PWR,
    S_INIT_NIB,
    S_INIT_WAIT,
    S_IDLE,
    S_HI,
    S_GAP,
    S_LO,
    S_EXEC
  } wr_state_e;

  typedef enum logic [1:0] {
    N_IDLE,
    N_SETUP,
    N_PULSE,
    N_HOLD
  } nib_state_e;

  // Init nibbles are 0x3, 0x3, 0x3 and finally 0x2 to switch the panel into 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Emits one timed nibble on the LCD bus: SETUP (E low), PULSE (E high), HOLD (E low).
module lcd_nibble_strobe
  import lcd_byte_writer_pkg::*;
#(
  parameter int unsigned T_SETUP = LCD_T_SETUP,
  parameter int unsigned T_PULSE = LCD_T_PULSE,
  parameter int unsigned T_HOLD  = LCD_T_HOLD,
  parameter int unsigned CNT_W   = LCD_CNT_W
) (
  input  logic       CCLK,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       LCDE,
  output logic [3:0] LCDDAT,
  output logic       LCDRS,
  output logic       done
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);

  nib_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);
  assign done       = (r_state == N_HOLD) && w_cnt_zero;

  // Data and RS are only loaded from idle, so they cannot move while E is high.
  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      r_state <= N_IDLE;
      r_cnt   <= '0;
      LCDE    <= 1'b0;
      LCDDAT  <= 4'h0;
      LCDRS   <= 1'b0;
    end else begin
      case (r_state)
        N_IDLE: begin
          if (start) begin
            r_state <= N_SETUP;
            r_cnt   <= SETUP_LD;
            LCDDAT  <= nibble;
            LCDRS   <= rs;
          end
        end
        N_SETUP: begin
          if (w_cnt_zero) begin
            r_state <= N_PULSE;
            r_cnt   <= PULSE_LD;
            LCDE    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        N_PULSE: begin
          if (w_cnt_zero) begin
            r_state <= N_HOLD;
            r_cnt   <= HOLD_LD;
            LCDE    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        N_HOLD: begin
          if (w_cnt_zero) begin
            r_state <= N_IDLE;
            LCDDAT  <= 4'h0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= N_IDLE;
          LCDE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit writer: self-runs the power-on init, then sends accepted bytes as two
// timed nibbles followed by the command execution wait.
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int unsigned T_POWERUP = LCD_T_POWERUP,
  parameter int unsigned T_INIT1   = LCD_T_INIT1,
  parameter int unsigned T_INIT2   = LCD_T_INIT2,
  parameter int unsigned T_CMD     = LCD_T_CMD,
  parameter int unsigned T_CLEAR   = LCD_T_CLEAR,
  parameter int unsigned T_SETUP   = LCD_T_SETUP,
  parameter int unsigned T_PULSE   = LCD_T_PULSE,
  parameter int unsigned T_HOLD    = LCD_T_HOLD,
  parameter int unsigned T_NIBGAP  = LCD_T_NIBGAP,
  parameter int unsigned CNT_W     = LCD_CNT_W
) (
  input  logic       CCLK,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       LCDE,
  output logic       LCDRS,
  output logic       LCDRW,
  output logic [3:0] LCDDAT
);

  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] INIT1_LD = CNT_W'(T_INIT1 - 1);
  localparam logic [CNT_W-1:0] INIT2_LD = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(T_NIBGAP - 1);

  wr_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic             r_pwr_armed;
  logic             r_ready;
  logic             r_init_done;
  logic             r_rs;
  logic [7:0]       r_data;

  logic             w_cnt_zero;
  logic             w_accept;
  logic             w_start;
  logic [3:0]       w_nib;
  logic             w_rs;
  logic             w_nib_done;
  logic             w_is_clear;
  logic [CNT_W-1:0] w_wait_ld;

  assign LCDRW     = 1'b0;
  assign wr_ready  = r_ready;
  assign init_done = r_init_done;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_accept   = (r_state == S_IDLE) && r_ready && wr_valid;
  assign w_is_clear = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));

  always_comb begin
    case (r_idx)
      2'd0:    w_wait_ld = INIT1_LD;
      2'd1:    w_wait_ld = INIT2_LD;
      default: w_wait_ld = CMD_LD;
    endcase
  end

  // Strobe start is combinational so the next nibble's SETUP begins on the exit edge.
  always_comb begin
    w_start = 1'b0;
    w_nib   = 4'h0;
    w_rs    = 1'b0;
    case (r_state)
      S_PWR: begin
        if (r_pwr_armed && w_cnt_zero) begin
          w_start = 1'b1;
          w_nib   = init_nibble(2'd0);
        end
      end
      S_INIT_WAIT: begin
        if (w_cnt_zero && (r_idx != 2'd3)) begin
          w_start = 1'b1;
          w_nib   = init_nibble(r_idx + 2'd1);
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          w_start = 1'b1;
          w_nib   = wr_data[7:4];
          w_rs    = wr_rs;
        end
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          w_start = 1'b1;
          w_nib   = r_data[3:0];
          w_rs    = r_rs;
        end
      end
      default: ;
    endcase
  end

  // The first cycle out of reset only arms the power-up counter.
  always_ff @(posedge CCLK or posedge rst) begin
    if (rst) begin
      r_state     <= S_PWR;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_pwr_armed <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      case (r_state)
        S_PWR: begin
          if (!r_pwr_armed) begin
            r_pwr_armed <= 1'b1;
            r_cnt       <= PWR_LD;
          end else if (w_cnt_zero) begin
            r_state <= S_INIT_NIB;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_INIT_NIB: begin
          if (w_nib_done) begin
            r_state <= S_INIT_WAIT;
            r_cnt   <= w_wait_ld;
          end
        end
        S_INIT_WAIT: begin
          if (w_cnt_zero) begin
            if (r_idx == 2'd3) begin
              r_state     <= S_IDLE;
              r_init_done <= 1'b1;
              r_ready     <= 1'b1;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_INIT_NIB;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_rs    <= wr_rs;
            r_data  <= wr_data;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (w_nib_done) begin
            r_state <= S_GAP;
            r_cnt   <= GAP_LD;
          end
        end
        S_GAP: begin
          if (w_cnt_zero) begin
            r_state <= S_LO;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LO: begin
          if (w_nib_done) begin
            r_state <= S_EXEC;
            r_cnt   <= w_is_clear ? CLEAR_LD : CMD_LD;
          end
        end
        S_EXEC: begin
          if (w_cnt_zero) begin
            r_state <= S_IDLE;
            r_ready <= r_init_done;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_PWR;
      endcase
    end
  end

  lcd_nibble_strobe #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD),
    .CNT_W   (CNT_W)
  ) u_strobe (
    .CCLK   (CCLK),
    .rst    (rst),
    .start  (w_start),
    .nibble (w_nib),
    .rs     (w_rs),
    .LCDE   (LCDE),
    .LCDDAT (LCDDAT),
    .LCDRS  (LCDRS),
    .done   (w_nib_done)
  );

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer with short timing and a free-running bus protocol checker.
module tb_lcd_byte_writer;

  logic       CCLK = 1'b0;
  logic       rst  = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       init_done;
  logic       LCDE;
  logic       LCDRS;
  logic       LCDRW;
  logic [3:0] LCDDAT;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] pulses[$];
  logic [3:0] cap_dat[1:40];
  logic       cap_e[1:40];
  logic       cap_rs[1:40];

  always #5 CCLK = ~CCLK;

  lcd_byte_writer #(
    .T_POWERUP (10),
    .T_INIT1   (8),
    .T_INIT2   (4),
    .T_CMD     (3),
    .T_CLEAR   (20),
    .T_SETUP   (2),
    .T_PULSE   (3),
    .T_HOLD    (1),
    .T_NIBGAP  (2),
    .CNT_W     (20)
  ) dut (
    .CCLK      (CCLK),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .init_done (init_done),
    .LCDE      (LCDE),
    .LCDRS     (LCDRS),
    .LCDRW     (LCDRW),
    .LCDDAT    (LCDDAT)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CCLK);
    #1;
  endtask

  // Bus protocol checker, sampled on the falling edge.
  initial begin
    logic       prev_e;
    logic [3:0] prev_dat;
    logic       prev_rs;
    int         e_width;
    prev_e   = 1'b0;
    prev_dat = 4'h0;
    prev_rs  = 1'b0;
    e_width  = 0;
    forever begin
      @(negedge CCLK);
      if (rst) begin
        prev_e  = 1'b0;
        e_width = 0;
      end else begin
        check_eq("lcdrw_zero", 32'(LCDRW), 32'd0);
        if (LCDE) begin
          if (prev_e) begin
            check_eq("dat_stable_e_high", 32'(LCDDAT), 32'(prev_dat));
            check_eq("rs_stable_e_high", 32'(LCDRS), 32'(prev_rs));
          end else begin
            pulses.push_back({LCDRS, LCDDAT});
          end
          e_width++;
        end else if (prev_e) begin
          check_eq("e_pulse_width", 32'(e_width), 32'd3);
          e_width = 0;
        end
        prev_e   = LCDE;
        prev_dat = LCDDAT;
        prev_rs  = LCDRS;
      end
    end
  end

  // Holds rst, checks reset outputs, releases and measures the init sequence.
  task automatic run_init(input string tag);
    int rise;
    rise     = 0;
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'hA5;
    rst      = 1'b1;
    repeat (2) step();
    check_eq({tag, "_rst_ready"}, 32'(wr_ready), 32'd0);
    check_eq({tag, "_rst_done"}, 32'(init_done), 32'd0);
    check_eq({tag, "_rst_e"}, 32'(LCDE), 32'd0);
    check_eq({tag, "_rst_rs"}, 32'(LCDRS), 32'd0);
    check_eq({tag, "_rst_dat"}, 32'(LCDDAT), 32'd0);
    pulses.delete();
    @(negedge CCLK);
    rst = 1'b0;
    for (int n = 1; n <= 70 && rise == 0; n++) begin
      step();
      if (init_done) rise = n;
    end
    check_eq({tag, "_done_edge"}, 32'(rise), 32'd53);
    check_eq({tag, "_ready_at_done"}, 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
    repeat (3) step();
    check_eq({tag, "_pulse_count"}, 32'(pulses.size()), 32'd4);
    if (pulses.size() == 4) begin
      check_eq({tag, "_nib0"}, 32'(pulses[0]), 32'h03);
      check_eq({tag, "_nib1"}, 32'(pulses[1]), 32'h03);
      check_eq({tag, "_nib2"}, 32'(pulses[2]), 32'h03);
      check_eq({tag, "_nib3"}, 32'(pulses[3]), 32'h02);
    end
    check_eq({tag, "_ready_idle"}, 32'(wr_ready), 32'd1);
  endtask

  // Presents one byte at an idle sample point; records cycles 1..40 after the accept edge.
  task automatic send_capture(input logic rs, input logic [7:0] d, output int ret);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    ret      = 0;
    for (int c = 1; c <= 40; c++) begin
      cap_dat[c] = LCDDAT;
      cap_e[c]   = LCDE;
      cap_rs[c]  = LCDRS;
      if (wr_ready && ret == 0) ret = c;
      if (c < 40) step();
    end
  endtask

  initial begin
    int         ret;
    int         idx;
    int         cyc;
    int         acc[3];
    logic       b_rs[3];
    logic [7:0] b_dat[3];
    logic [4:0] exp_nib[6];
    logic       sampled;

    run_init("init");

    // Single data byte 'A'
    pulses.delete();
    send_capture(1'b1, 8'h41, ret);
    check_eq("b41_dat_c1", 32'(cap_dat[1]), 32'h4);
    check_eq("b41_dat_c6", 32'(cap_dat[6]), 32'h4);
    check_eq("b41_e_c2", 32'(cap_e[2]), 32'd0);
    check_eq("b41_e_c3", 32'(cap_e[3]), 32'd1);
    check_eq("b41_e_c5", 32'(cap_e[5]), 32'd1);
    check_eq("b41_e_c6", 32'(cap_e[6]), 32'd0);
    check_eq("b41_dat_c9", 32'(cap_dat[9]), 32'h1);
    check_eq("b41_dat_c14", 32'(cap_dat[14]), 32'h1);
    check_eq("b41_e_c10", 32'(cap_e[10]), 32'd0);
    check_eq("b41_e_c11", 32'(cap_e[11]), 32'd1);
    check_eq("b41_e_c13", 32'(cap_e[13]), 32'd1);
    check_eq("b41_e_c14", 32'(cap_e[14]), 32'd0);
    check_eq("b41_rs_c1", 32'(cap_rs[1]), 32'd1);
    check_eq("b41_rs_c17", 32'(cap_rs[17]), 32'd1);
    check_eq("b41_ready_cycle", 32'(ret), 32'd18);
    check_eq("b41_pulses", 32'(pulses.size()), 32'd2);
    if (pulses.size() == 2) begin
      check_eq("b41_hi", 32'(pulses[0]), 32'h14);
      check_eq("b41_lo", 32'(pulses[1]), 32'h11);
    end

    // Execution wait selection
    send_capture(1'b0, 8'h01, ret);
    check_eq("clear01_ready_cycle", 32'(ret), 32'd35);
    check_eq("clear01_rs_c20", 32'(cap_rs[20]), 32'd0);
    send_capture(1'b0, 8'h02, ret);
    check_eq("home02_ready_cycle", 32'(ret), 32'd35);
    send_capture(1'b0, 8'h28, ret);
    check_eq("cmd28_ready_cycle", 32'(ret), 32'd18);
    send_capture(1'b1, 8'h01, ret);
    check_eq("data01_ready_cycle", 32'(ret), 32'd18);
    send_capture(1'b0, 8'h03, ret);
    check_eq("cmd03_ready_cycle", 32'(ret), 32'd18);

    // Back-to-back with wr_valid held high
    b_rs[0] = 1'b1; b_dat[0] = 8'h5A;
    b_rs[1] = 1'b1; b_dat[1] = 8'hC3;
    b_rs[2] = 1'b0; b_dat[2] = 8'h28;
    exp_nib[0] = 5'h15; exp_nib[1] = 5'h1A;
    exp_nib[2] = 5'h1C; exp_nib[3] = 5'h13;
    exp_nib[4] = 5'h02; exp_nib[5] = 5'h08;
    pulses.delete();
    idx      = 0;
    cyc      = 0;
    wr_valid = 1'b1;
    wr_rs    = b_rs[0];
    wr_data  = b_dat[0];
    while (idx < 3 && cyc < 200) begin
      sampled = wr_ready;
      step();
      cyc++;
      if (sampled) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          wr_rs   = b_rs[idx];
          wr_data = b_dat[idx];
        end else begin
          wr_valid = 1'b0;
        end
      end
    end
    check_eq("b2b_accept_count", 32'(idx), 32'd3);
    if (idx == 3) begin
      check_eq("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'd18);
      check_eq("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'd18);
    end
    repeat (30) step();
    check_eq("b2b_pulse_count", 32'(pulses.size()), 32'd6);
    if (pulses.size() == 6) begin
      for (int i = 0; i < 6; i++) check_eq("b2b_nibble", 32'(pulses[i]), 32'(exp_nib[i]));
    end
    check_eq("b2b_ready_end", 32'(wr_ready), 32'd1);

    // Reset during the low-nibble pulse
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h41;
    step();
    wr_valid = 1'b0;
    repeat (11) step();
    check_eq("midrst_e_before", 32'(LCDE), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_e_async", 32'(LCDE), 32'd0);
    check_eq("midrst_ready_async", 32'(wr_ready), 32'd0);
    check_eq("midrst_done_async", 32'(init_done), 32'd0);
    check_eq("midrst_dat_async", 32'(LCDDAT), 32'd0);
    run_init("reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
